// File: rtl/iddr_deser.sv
// rtl/iddr_deser.sv - DDR input-register emulation: serial bits in, Q1/Q2 pairs out.
// Optional bit-slip input when IDDR_BITSLIP_EN is defined.
module iddr_deser #(
  parameter string DDR_CLK_EDGE = "OPPOSITE_EDGE",
  parameter logic  INIT_Q1      = 1'b0,
  parameter logic  INIT_Q2      = 1'b0
) (
  input  logic C,
  input  logic R_N,
  input  logic CE,
  input  logic D,
  input  logic R,
  input  logic S,
`ifdef IDDR_BITSLIP_EN
  input  logic BITSLIP,
`endif
  output logic Q1,
  output logic Q2,
  output logic VALID,
  output logic PHASE
);

  localparam bit MODE_OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
  localparam bit MODE_SAME = (DDR_CLK_EDGE == "SAME_EDGE");
  localparam bit MODE_PIPE = (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED");

  generate
    if (!(MODE_OPP || MODE_SAME || MODE_PIPE)) begin : g_bad_mode
      $fatal(1, "iddr_deser: unsupported DDR_CLK_EDGE %s", DDR_CLK_EDGE);
    end
  endgenerate

  logic slip;
`ifdef IDDR_BITSLIP_EN
  assign slip = BITSLIP;
`else
  assign slip = 1'b0;
`endif

  logic ph_q, ph_d;
  logic cap1_q, cap1_d;
  logic cap2_q, cap2_d;
  logic q1_q, q1_d;
  logic q2_q, q2_d;
  logic valid_q, valid_d;
  // Pipelined mode only: a full pair has been captured since the last reset/set.
  logic pend_q, pend_d;

  always_comb begin
    ph_d    = ph_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    valid_d = 1'b0;
    pend_d  = pend_q;
    if (R) begin
      ph_d   = 1'b0;
      cap1_d = 1'b0;
      cap2_d = 1'b0;
      q1_d   = 1'b0;
      q2_d   = 1'b0;
      pend_d = 1'b0;
    end else if (S) begin
      cap1_d = 1'b1;
      cap2_d = 1'b1;
      q1_d   = 1'b1;
      q2_d   = 1'b1;
      pend_d = 1'b0;
    end else if (CE && !slip) begin
      ph_d = ~ph_q;
      if (!ph_q) cap1_d = D;
      else       cap2_d = D;
      if (MODE_OPP) begin
        if (!ph_q) begin
          q1_d = D;
        end else begin
          q2_d    = D;
          valid_d = 1'b1;
        end
      end else if (MODE_SAME) begin
        if (ph_q) begin
          q1_d    = cap1_q;
          q2_d    = D;
          valid_d = 1'b1;
        end
      end else begin
        // Present the pair captured last time while the new first bit lands in cap1.
        if (ph_q) begin
          pend_d = 1'b1;
        end else if (pend_q) begin
          q1_d    = cap1_q;
          q2_d    = cap2_q;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      ph_q    <= 1'b0;
      cap1_q  <= INIT_Q1;
      cap2_q  <= INIT_Q2;
      q1_q    <= INIT_Q1;
      q2_q    <= INIT_Q2;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign Q1    = q1_q;
  assign Q2    = q2_q;
  assign VALID = valid_q;
  assign PHASE = ph_q;

endmodule

// File: tb/tb_iddr_deser.sv
// tb/tb_iddr_deser.sv - self-checking bench for iddr_deser in all three output modes.
// Bit-slip vectors run only when IDDR_BITSLIP_EN is defined.
module tb_iddr_deser;

  logic C = 1'b0;
  logic R_N, CE, D, R, S, BITSLIP;
  logic o_q1, o_q2, o_v, o_p;
  logic s_q1, s_q2, s_v, s_p;
  logic p_q1, p_q2, p_v, p_p;

  always #5 C = ~C;

  iddr_deser #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b0)) u_opp (
    .C(C), .R_N(R_N), .CE(CE), .D(D), .R(R), .S(S),
`ifdef IDDR_BITSLIP_EN
    .BITSLIP(BITSLIP),
`endif
    .Q1(o_q1), .Q2(o_q2), .VALID(o_v), .PHASE(o_p)
  );

  iddr_deser #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT_Q1(1'b1), .INIT_Q2(1'b0)) u_same (
    .C(C), .R_N(R_N), .CE(CE), .D(D), .R(R), .S(S),
`ifdef IDDR_BITSLIP_EN
    .BITSLIP(BITSLIP),
`endif
    .Q1(s_q1), .Q2(s_q2), .VALID(s_v), .PHASE(s_p)
  );

  iddr_deser #(.DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .INIT_Q1(1'b0), .INIT_Q2(1'b0)) u_pipe (
    .C(C), .R_N(R_N), .CE(CE), .D(D), .R(R), .S(S),
`ifdef IDDR_BITSLIP_EN
    .BITSLIP(BITSLIP),
`endif
    .Q1(p_q1), .Q2(p_q2), .VALID(p_v), .PHASE(p_p)
  );

  // Expected outputs are packed {Q1, Q2, VALID, PHASE} per instance.
  typedef struct packed {
    logic       r;
    logic       s;
    logic       ce;
    logic       d;
    logic       bs;
    logic [3:0] e_opp;
    logic [3:0] e_same;
    logic [3:0] e_pipe;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          step  = 0;

  function automatic vec_t v(input logic r, input logic s, input logic ce, input logic d,
                             input logic bs, input logic [3:0] eo, input logic [3:0] es,
                             input logic [3:0] ep);
    vec_t t;
    t = {r, s, ce, d, bs, eo, es, ep};
    return t;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [3:0] got,
                     input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got Q1Q2VP=%b want %b", name, idx, got, want);
    end
  endtask

  task automatic check_all(input int idx);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue want entry", idx);
    end else begin
      e = exp_q.pop_front();
      cmp("opp",  idx, {o_q1, o_q2, o_v, o_p}, e[11:8]);
      cmp("same", idx, {s_q1, s_q2, s_v, s_p}, e[7:4]);
      cmp("pipe", idx, {p_q1, p_q2, p_v, p_p}, e[3:0]);
    end
  endtask

  task automatic run_vec(input vec_t t);
    R       = t.r;
    S       = t.s;
    CE      = t.ce;
    D       = t.d;
    BITSLIP = t.bs;
    exp_q.push_back({t.e_opp, t.e_same, t.e_pipe});
    @(posedge C);
    @(negedge C);
    step++;
    check_all(step);
  endtask

  initial begin
    R_N = 1'b1; CE = 1'b0; D = 1'b0; R = 1'b0; S = 1'b0; BITSLIP = 1'b0;
    #2 R_N = 1'b0;
    #1;
    cmp("rst_opp",  0, {o_q1, o_q2, o_v, o_p}, 4'b0000);
    cmp("rst_same", 0, {s_q1, s_q2, s_v, s_p}, 4'b1000);
    cmp("rst_pipe", 0, {p_q1, p_q2, p_v, p_p}, 4'b0000);
    @(negedge C);
    R_N = 1'b1;

    //           r     s     ce    d     bs    opp      same     pipe
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 4'b0001));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 4'b1011));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1110, 4'b1110, 4'b1000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b1101, 4'b1111));
    tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 4'b1101, 4'b1101));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'b1100));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b0111));
    tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 4'b1101, 4'b1101));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 4'b1100, 4'b1100));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1101, 4'b1101, 4'b1101));
    tbl.push_back(v(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b0111));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0100));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b0001, 4'b0011));
`ifdef IDDR_BITSLIP_EN
    tbl.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b0001, 4'b0001));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0000));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1001, 4'b1011));
    tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b1001, 4'b1001));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1001, 4'b1001));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'b1000));
`endif

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset mid-run: outputs return to INIT values before any edge.
    R_N = 1'b0;
    #1;
    cmp("arst_opp",  step, {o_q1, o_q2, o_v, o_p}, 4'b0000);
    cmp("arst_same", step, {s_q1, s_q2, s_v, s_p}, 4'b1000);
    cmp("arst_pipe", step, {p_q1, p_q2, p_v, p_p}, 4'b0000);
    #1 R_N = 1'b1;
    run_vec(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 4'b0001));
    run_vec(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b0000));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
